// File: rtl/argmax_result_if.sv
// Score stream in, classification result out, between the last FC layer,
// the argmax stage and the accuracy-count/UART stage.
//   in_valid/in_ready/in_data/in_last : score beats, one per class
//   final_number/max_score            : winning class and its score, held
//   uart_en/frame_err                 : one-cycle result / framing strobes
//   frame_cnt                         : emitted-result counter
// master = score producer / result consumer; slave = argmax_result.
interface argmax_result_if #(
  parameter int unsigned DWIDTH = 16,
  parameter int unsigned IDX_W  = 4
);
  logic              in_valid;
  logic              in_ready;
  logic [DWIDTH-1:0] in_data;
  logic              in_last;
  logic [IDX_W-1:0]  final_number;
  logic [DWIDTH-1:0] max_score;
  logic              uart_en;
  logic              frame_err;
  logic [15:0]       frame_cnt;

  modport master (
    output in_valid, in_data, in_last,
    input  in_ready, final_number, max_score, uart_en, frame_err, frame_cnt
  );

  modport slave (
    input  in_valid, in_data, in_last,
    output in_ready, final_number, max_score, uart_en, frame_err, frame_cnt
  );
endinterface

// File: rtl/argmax_result.sv
// Final classification stage: tracks the running signed maximum over
// NUM_CLASS score beats and emits the winning class index per frame.
// Ports:
//   clk_25m : system clock
//   rst_n   : asynchronous active-low reset
//   bus     : argmax_result_if.slave (score stream in, result/debug out)
// All outputs, including in_ready, are registered.
module argmax_result #(
  parameter int unsigned NUM_CLASS = 10,
  parameter int unsigned DWIDTH    = 16,
  parameter int unsigned IDX_W     = 4
) (
  input  logic          clk_25m,
  input  logic          rst_n,
  argmax_result_if.slave bus
);

  localparam int unsigned CNT_W = 16;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ACCUM = 2'd1;
  localparam logic [1:0] S_EMIT  = 2'd2;

  localparam logic [IDX_W-1:0] LAST_BEAT = IDX_W'(NUM_CLASS - 1);

  logic [1:0]        state_q, state_d;
  logic              in_ready_q, in_ready_d;
  logic [IDX_W-1:0]  beat_q, beat_d;
  logic [DWIDTH-1:0] cur_max_q, cur_max_d;
  logic [IDX_W-1:0]  cur_idx_q, cur_idx_d;
  logic [IDX_W-1:0]  final_number_q, final_number_d;
  logic [DWIDTH-1:0] max_score_q, max_score_d;
  logic              uart_en_q, uart_en_d;
  logic              frame_err_q, frame_err_d;
  logic [CNT_W-1:0]  frame_cnt_q, frame_cnt_d;

  logic              accept;
  logic              take;
  logic [IDX_W-1:0]  beat_idx;
  logic [DWIDTH-1:0] upd_max;
  logic [IDX_W-1:0]  upd_idx;

  // Next-state and output logic
  always_comb begin
    state_d        = state_q;
    beat_d         = beat_q;
    cur_max_d      = cur_max_q;
    cur_idx_d      = cur_idx_q;
    final_number_d = final_number_q;
    max_score_d    = max_score_q;
    frame_cnt_d    = frame_cnt_q;
    uart_en_d      = 1'b0;
    frame_err_d    = 1'b0;

    accept   = bus.in_valid && in_ready_q;
    // First beat of a frame always seeds the maximum, even at the most-negative value
    beat_idx = (state_q == S_IDLE) ? '0 : beat_q;
    take     = (state_q == S_IDLE) || ($signed(bus.in_data) > $signed(cur_max_q));
    upd_max  = take ? bus.in_data : cur_max_q;
    upd_idx  = take ? beat_idx    : cur_idx_q;

    case (state_q)
      S_IDLE, S_ACCUM: begin
        if (accept) begin
          if (beat_idx == LAST_BEAT) begin
            // Result registers load here so they appear together with uart_en
            state_d        = S_EMIT;
            beat_d         = '0;
            final_number_d = upd_idx;
            max_score_d    = upd_max;
            uart_en_d      = 1'b1;
            frame_cnt_d    = frame_cnt_q + CNT_W'(1);
            frame_err_d    = !bus.in_last;
          end else if (bus.in_last) begin
            // Early end of frame: drop the partial result
            state_d     = S_IDLE;
            beat_d      = '0;
            frame_err_d = 1'b1;
          end else begin
            state_d   = S_ACCUM;
            beat_d    = beat_idx + IDX_W'(1);
            cur_max_d = upd_max;
            cur_idx_d = upd_idx;
          end
        end
      end
      S_EMIT: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        beat_d  = '0;
      end
    endcase

    // Bubble exactly during the emit cycle
    in_ready_d = (state_d != S_EMIT);
  end

  // State and output registers
  always_ff @(posedge clk_25m or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      in_ready_q     <= 1'b0;
      beat_q         <= '0;
      cur_max_q      <= '0;
      cur_idx_q      <= '0;
      final_number_q <= '0;
      max_score_q    <= '0;
      uart_en_q      <= 1'b0;
      frame_err_q    <= 1'b0;
      frame_cnt_q    <= '0;
    end else begin
      state_q        <= state_d;
      in_ready_q     <= in_ready_d;
      beat_q         <= beat_d;
      cur_max_q      <= cur_max_d;
      cur_idx_q      <= cur_idx_d;
      final_number_q <= final_number_d;
      max_score_q    <= max_score_d;
      uart_en_q      <= uart_en_d;
      frame_err_q    <= frame_err_d;
      frame_cnt_q    <= frame_cnt_d;
    end
  end

  assign bus.in_ready     = in_ready_q;
  assign bus.final_number = final_number_q;
  assign bus.max_score    = max_score_q;
  assign bus.uart_en      = uart_en_q;
  assign bus.frame_err    = frame_err_q;
  assign bus.frame_cnt    = frame_cnt_q;

endmodule

// File: tb/tb_argmax_result.sv
// Directed bench for argmax_result with a result scoreboard.
module tb_argmax_result;

  logic clk_25m = 1'b0;
  logic rst_n   = 1'b0;

  always #20 clk_25m = ~clk_25m;

  argmax_result_if #(.DWIDTH(16), .IDX_W(4)) bus ();

  argmax_result #(.NUM_CLASS(10), .DWIDTH(16), .IDX_W(4)) dut (
    .clk_25m (clk_25m),
    .rst_n   (rst_n),
    .bus     (bus.slave)
  );

  typedef int ivec_t [10];

  typedef struct packed {
    logic        emit;
    logic        err;
    logic [3:0]  idx;
    logic [15:0] mx;
    logic [15:0] cnt;
  } exp_t;

  exp_t        sb_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [3:0]  model_fn  = '0;
  logic [15:0] model_mx  = '0;
  logic [15:0] model_cnt = '0;
  int          exp_cnt   = 0;
  logic        prev_uart = 1'b0;
  exp_t        got;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Output monitor: pops the scoreboard on each strobe and checks held values otherwise
  always @(negedge clk_25m) begin
    if (rst_n) begin
      if (bus.uart_en || bus.frame_err) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_strobe", 32'({bus.uart_en, bus.frame_err}), 32'd0);
        end else begin
          got = sb_q.pop_front();
          chk("uart_en",   32'(bus.uart_en),   32'(got.emit));
          chk("frame_err", 32'(bus.frame_err), 32'(got.err));
          if (got.emit) begin
            model_fn  = got.idx;
            model_mx  = got.mx;
            model_cnt = got.cnt;
            chk("in_ready_emit", 32'(bus.in_ready), 32'd0);
          end
          chk("final_number", 32'(bus.final_number), 32'(model_fn));
          chk("max_score",    32'(bus.max_score),    32'(model_mx));
          chk("frame_cnt",    32'(bus.frame_cnt),    32'(model_cnt));
        end
      end else begin
        chk("hold_final_number", 32'(bus.final_number), 32'(model_fn));
        chk("hold_frame_cnt",    32'(bus.frame_cnt),    32'(model_cnt));
        if (prev_uart) chk("in_ready_after_emit", 32'(bus.in_ready), 32'd1);
      end
      prev_uart = bus.uart_en;
    end else begin
      prev_uart = 1'b0;
    end
  end

  task automatic beat(input logic [15:0] d, input logic last);
    int k;
    @(negedge clk_25m);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = last;
    k = 0;
    while (!bus.in_ready && k < 50) begin
      @(negedge clk_25m);
      k++;
    end
    chk("ready_wait", 32'(bus.in_ready), 32'd1);
    @(posedge clk_25m);
    #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  // last_at: beat carrying in_last (-1 = none); pushes the expected outcome first
  task automatic send_frame(input ivec_t v, input int last_at, input bit gaps);
    int   n;
    int   best;
    int   bi;
    exp_t e;
    n = (last_at >= 0 && last_at < 9) ? last_at + 1 : 10;
    if (n < 10) begin
      e = '{emit: 1'b0, err: 1'b1, idx: 4'd0, mx: 16'd0, cnt: 16'd0};
    end else begin
      best = v[0];
      bi   = 0;
      for (int i = 1; i < 10; i++) begin
        if (v[i] > best) begin
          best = v[i];
          bi   = i;
        end
      end
      exp_cnt++;
      e = '{emit: 1'b1, err: (last_at != 9), idx: 4'(bi), mx: 16'(best), cnt: 16'(exp_cnt)};
    end
    sb_q.push_back(e);
    for (int i = 0; i < n; i++) begin
      if (gaps) repeat ($urandom_range(0, 3)) @(negedge clk_25m);
      beat(16'(v[i]), (i == last_at));
    end
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (sb_q.size() != 0 && k < 30) begin
      @(negedge clk_25m);
      k++;
    end
    chk("drain", 32'(sb_q.size()), 32'd0);
    repeat (2) @(negedge clk_25m);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_in_ready"},     32'(bus.in_ready),     32'd0);
    chk({tag, "_final_number"}, 32'(bus.final_number), 32'd0);
    chk({tag, "_max_score"},    32'(bus.max_score),    32'd0);
    chk({tag, "_uart_en"},      32'(bus.uart_en),      32'd0);
    chk({tag, "_frame_err"},    32'(bus.frame_err),    32'd0);
    chk({tag, "_frame_cnt"},    32'(bus.frame_cnt),    32'd0);
  endtask

  ivec_t f;

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.in_last  = 1'b0;

    repeat (3) @(negedge clk_25m);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk_25m);

    // Mixed scores, continuous valid: max 12 at index 2
    f = '{3, -5, 12, 7, 0, 1, 2, 9, -1, 4};
    send_frame(f, 9, 1'b0);
    drain();

    // All most-negative scores: index 0 wins
    f = '{-32768, -32768, -32768, -32768, -32768, -32768, -32768, -32768, -32768, -32768};
    send_frame(f, 9, 1'b0);
    drain();

    // Tie at indices 1 and 2: lowest index wins
    f = '{5, 9, 9, 1, 0, -2, 3, 4, 8, 7};
    send_frame(f, 9, 1'b0);
    drain();

    // Back-to-back frames with gaps: max at index 9 then index 0
    f = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 100};
    send_frame(f, 9, 1'b1);
    f = '{50, 1, -7, 49, 0, 3, 2, 1, 48, -3};
    send_frame(f, 9, 1'b1);
    drain();

    // Early in_last on beat 4: framing error only, result held
    f = '{1, 2, 999, 4, 5, 6, 7, 8, 9, 10};
    send_frame(f, 4, 1'b0);
    drain();

    // Full frame after the error: max at index 3
    f = '{-1, -2, -3, 77, -5, 76, 0, 0, 0, 0};
    send_frame(f, 9, 1'b1);
    drain();

    // No in_last at all: result plus simultaneous frame_err, max at index 5
    f = '{10, 20, 30, 40, 50, 321, 60, 70, 80, -90};
    send_frame(f, -1, 1'b0);
    drain();

    // Reset after beat 5 of a frame discards it and clears held outputs
    f = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 100};
    for (int i = 0; i < 6; i++) beat(16'(f[i]), 1'b0);
    @(negedge clk_25m);
    rst_n = 1'b0;
    sb_q.delete();
    model_fn  = '0;
    model_mx  = '0;
    model_cnt = '0;
    exp_cnt   = 0;
    #5;
    check_reset_outputs("midreset");
    repeat (3) @(negedge clk_25m);
    rst_n = 1'b1;
    repeat (2) @(negedge clk_25m);

    f = '{0, 1, 2, 3, 4, 5, 600, 7, 8, 9};
    send_frame(f, 9, 1'b0);
    drain();
    chk("final_after_reset", 32'(bus.final_number), 32'd6);
    chk("cnt_after_reset",   32'(bus.frame_cnt),    32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
